vcache_stat_snapshot: RTL and testbench

VCACHE_STAT_SNAPSHOT -- requirements
Module: vcache_stat_snapshot

---
 rtl/vcache_stat_snapshot.sv | 183 ++++++++++++++++++
 tb/tb_vcache_stat_snapshot.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vcache_stat_snapshot.sv
// vcache_stat_snapshot: per-event live counters with an atomic snapshot that is
// read out as a stream of 32-bit words: global counter, tag, then each counter.
// Optional build macro VCACHE_STAT_SNAPSHOT_SAT_EN: when defined, the live
// counters saturate at all-ones. When undefined, they wrap modulo 2^ctr_width_p.
module vcache_stat_snapshot #(
    parameter int num_events_p    = 4,
    parameter int ctr_width_p     = 32,
    parameter int tag_width_p     = 32,
    parameter int clear_on_snap_p = 0,
    localparam int idx_width_lp   = $clog2(num_events_p + 2)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [num_events_p-1:0] event_i,
    input  logic [31:0]             global_ctr_i,
    input  logic                    snap_v_i,
    input  logic [tag_width_p-1:0]  snap_tag_i,
    output logic                    snap_yumi_o,
    output logic                    v_o,
    output logic [31:0]             data_o,
    output logic [idx_width_lp-1:0] idx_o,
    input  logic                    ready_i,
    output logic [15:0]             dropped_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR_CTR = 2'd1,
        HDR_TAG = 2'd2,
        CNT     = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ctr_width_p-1:0]  r_ctr    [num_events_p];
    logic [ctr_width_p-1:0]  r_shadow [num_events_p];
    logic [tag_width_p-1:0]  r_shadow_tag;
    logic                    r_v;
    logic [31:0]             r_data;
    logic [idx_width_lp-1:0] r_idx;
    logic [15:0]             r_dropped;

    logic                    w_accept;
    logic                    w_clear;
    logic                    w_xfer;
    logic [ctr_width_p-1:0]  w_ctr_inc [num_events_p];
    logic [31:0]             w_sel_cnt;

    // Accept only in IDLE; reset suppresses the handshake.
    assign w_accept    = snap_v_i & (r_state == IDLE) & ~reset_i;
    assign w_clear     = w_accept & (clear_on_snap_p != 0);
    assign w_xfer      = r_v & ready_i;
    assign snap_yumi_o = w_accept;
    assign v_o         = r_v;
    assign data_o      = r_data;
    assign idx_o       = r_idx;
    assign dropped_o   = r_dropped;

    // Incremented value of each live counter (saturating or wrapping per build).
    always_comb begin
        for (int k = 0; k < num_events_p; k++) begin
`ifdef VCACHE_STAT_SNAPSHOT_SAT_EN
            w_ctr_inc[k] = (r_ctr[k] == {ctr_width_p{1'b1}}) ? r_ctr[k]
                                                              : r_ctr[k] + ctr_width_p'(1);
`else
            w_ctr_inc[k] = r_ctr[k] + ctr_width_p'(1);
`endif
        end
    end

    // Select the next counter word: r_idx-1 is the counter shown after the transfer.
    always_comb begin
        w_sel_cnt = 32'd0;
        for (int k = 0; k < num_events_p; k++) begin
            w_sel_cnt = w_sel_cnt |
                        ((r_idx == idx_width_lp'(k + 1)) ? 32'(r_shadow[k]) : 32'd0);
        end
    end

    // Live counters; shadow copy sees the pre-increment value in the accept cycle.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < num_events_p; k++) begin
            if (reset_i) begin
                r_ctr[k] <= '0;
            end else if (w_clear) begin
                r_ctr[k] <= ctr_width_p'(event_i[k]);
            end else if (event_i[k]) begin
                r_ctr[k] <= w_ctr_inc[k];
            end else begin
                r_ctr[k] <= r_ctr[k];
            end
        end
    end

    // Shadow registers loaded atomically on snapshot accept.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_shadow_tag <= '0;
            for (int k = 0; k < num_events_p; k++) begin
                r_shadow[k] <= '0;
            end
        end else if (w_accept) begin
            r_shadow_tag <= snap_tag_i;
            for (int k = 0; k < num_events_p; k++) begin
                r_shadow[k] <= r_ctr[k];
            end
        end else begin
            r_shadow_tag <= r_shadow_tag;
            for (int k = 0; k < num_events_p; k++) begin
                r_shadow[k] <= r_shadow[k];
            end
        end
    end

    // Readout FSM with registered valid/data/index; one word per transfer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_v     <= 1'b0;
            r_data  <= 32'd0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= HDR_CTR;
                        r_v     <= 1'b1;
                        r_data  <= global_ctr_i;
                        r_idx   <= '0;
                    end else begin
                        r_v    <= 1'b0;
                        r_data <= 32'd0;
                        r_idx  <= '0;
                    end
                end
                HDR_CTR: begin
                    if (w_xfer) begin
                        r_state <= HDR_TAG;
                        r_data  <= 32'(r_shadow_tag);
                        r_idx   <= idx_width_lp'(1);
                    end
                end
                HDR_TAG: begin
                    if (w_xfer) begin
                        r_state <= CNT;
                        r_data  <= w_sel_cnt;
                        r_idx   <= idx_width_lp'(2);
                    end
                end
                CNT: begin
                    if (w_xfer) begin
                        if (r_idx == idx_width_lp'(num_events_p + 1)) begin
                            r_state <= IDLE;
                            r_v     <= 1'b0;
                            r_data  <= 32'd0;
                            r_idx   <= '0;
                        end else begin
                            r_data <= w_sel_cnt;
                            r_idx  <= r_idx + idx_width_lp'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_v     <= 1'b0;
                    r_data  <= 32'd0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // Count refused requests, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_dropped <= 16'd0;
        end else if (snap_v_i && (r_state != IDLE) && (r_dropped != 16'hFFFF)) begin
            r_dropped <= r_dropped + 16'd1;
        end else begin
            r_dropped <= r_dropped;
        end
    end

endmodule

// File: tb/tb_vcache_stat_snapshot.sv
// Directed bench for vcache_stat_snapshot: default instance, clear-on-snap
// instance and an 8-bit counter instance, all driven by the same stimulus.
module tb_vcache_stat_snapshot;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic [3:0]  event_i = 4'd0;
    logic [31:0] global_ctr_i = 32'd0;
    logic        snap_v_i = 1'b0;
    logic [31:0] snap_tag_i = 32'd0;
    logic        ready_i = 1'b1;

    logic        yumi_a, v_a, yumi_c, v_c, yumi_w, v_w;
    logic [31:0] data_a, data_c, data_w;
    logic [2:0]  idx_a, idx_c, idx_w;
    logic [15:0] drop_a, drop_c, drop_w;

    int checks = 0;
    int errors = 0;

`ifdef VCACHE_STAT_SNAPSHOT_SAT_EN
    localparam logic [31:0] WRAP_EXP = 32'd255;
`else
    localparam logic [31:0] WRAP_EXP = 32'd4;
`endif

    always #5 clk = ~clk;

    vcache_stat_snapshot dut (
        .clk_i(clk), .reset_i(reset_i), .event_i(event_i), .global_ctr_i(global_ctr_i),
        .snap_v_i(snap_v_i), .snap_tag_i(snap_tag_i), .snap_yumi_o(yumi_a), .v_o(v_a),
        .data_o(data_a), .idx_o(idx_a), .ready_i(ready_i), .dropped_o(drop_a));

    vcache_stat_snapshot #(.clear_on_snap_p(1)) dut_c (
        .clk_i(clk), .reset_i(reset_i), .event_i(event_i), .global_ctr_i(global_ctr_i),
        .snap_v_i(snap_v_i), .snap_tag_i(snap_tag_i), .snap_yumi_o(yumi_c), .v_o(v_c),
        .data_o(data_c), .idx_o(idx_c), .ready_i(ready_i), .dropped_o(drop_c));

    vcache_stat_snapshot #(.ctr_width_p(8)) dut_w (
        .clk_i(clk), .reset_i(reset_i), .event_i(event_i), .global_ctr_i(global_ctr_i),
        .snap_v_i(snap_v_i), .snap_tag_i(snap_tag_i), .snap_yumi_o(yumi_w), .v_o(v_w),
        .data_o(data_w), .idx_o(idx_w), .ready_i(ready_i), .dropped_o(drop_w));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the currently presented word of one instance, then advance a cycle.
    task automatic chk_word(input int which, input int idx, input logic [31:0] exp);
        logic        v;
        logic [2:0]  ix;
        logic [31:0] d;
        case (which)
            1:       begin v = v_c; ix = idx_c; d = data_c; end
            2:       begin v = v_w; ix = idx_w; d = data_w; end
            default: begin v = v_a; ix = idx_a; d = data_a; end
        endcase
        chk($sformatf("v%0d_i%0d", which, idx), 32'(v), 32'd1);
        chk($sformatf("idx%0d_i%0d", which, idx), 32'(ix), 32'(idx));
        chk($sformatf("data%0d_i%0d", which, idx), d, exp);
        tick();
    endtask

    task automatic expect_readout(input int which, input logic [31:0] g, input logic [31:0] t,
                                  input logic [31:0] c0, input logic [31:0] c1,
                                  input logic [31:0] c2, input logic [31:0] c3);
        logic v;
        chk_word(which, 0, g);
        chk_word(which, 1, t);
        chk_word(which, 2, c0);
        chk_word(which, 3, c1);
        chk_word(which, 4, c2);
        chk_word(which, 5, c3);
        v = (which == 1) ? v_c : ((which == 2) ? v_w : v_a);
        chk($sformatf("idle_after%0d", which), 32'(v), 32'd0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_v", 32'(v_a), 32'd0);
        chk("rst_data", data_a, 32'd0);
        chk("rst_idx", 32'(idx_a), 32'd0);
        chk("rst_drop", 32'(drop_a), 32'd0);
        chk("rst_yumi", 32'(yumi_a), 32'd0);

        // Basic snapshot: 5 events on ctr0, 3 on ctr2
        event_i = 4'b0101;
        repeat (3) tick();
        event_i = 4'b0001;
        repeat (2) tick();
        event_i = 4'b0000;
        snap_v_i = 1'b1; global_ctr_i = 32'd100; snap_tag_i = 32'hAB;
        #1;
        chk("yumi_basic", 32'(yumi_a), 32'd1);
        tick();
        snap_v_i = 1'b0;
        expect_readout(0, 32'd100, 32'hAB, 32'd5, 32'd0, 32'd3, 32'd0);

        // Back-pressure at idx 2 plus a refused request
        snap_v_i = 1'b1; global_ctr_i = 32'd200; snap_tag_i = 32'h11;
        tick();
        snap_v_i = 1'b0;
        chk_word(0, 0, 32'd200);
        chk_word(0, 1, 32'h11);
        ready_i = 1'b0; event_i = 4'b0010; snap_v_i = 1'b1;
        #1;
        chk("yumi_busy", 32'(yumi_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("stall_v", 32'(v_a), 32'd1);
            chk("stall_idx", 32'(idx_a), 32'd2);
            chk("stall_data", data_a, 32'd5);
            tick();
            snap_v_i = 1'b0;
        end
        chk("dropped_one", 32'(drop_a), 32'd1);
        event_i = 4'b0000; ready_i = 1'b1;
        chk_word(0, 2, 32'd5);
        chk_word(0, 3, 32'd0);
        chk_word(0, 4, 32'd3);
        chk_word(0, 5, 32'd0);
        chk("idle_after_stall", 32'(v_a), 32'd0);

        // Stall events appear in the next snapshot; reset at idx 3
        snap_v_i = 1'b1; global_ctr_i = 32'd300; snap_tag_i = 32'h22;
        tick();
        snap_v_i = 1'b0;
        chk_word(0, 0, 32'd300);
        chk_word(0, 1, 32'h22);
        chk_word(0, 2, 32'd5);
        chk("pre_rst_idx", 32'(idx_a), 32'd3);
        chk("pre_rst_data", data_a, 32'd4);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("midrst_v", 32'(v_a), 32'd0);
        chk("midrst_idx", 32'(idx_a), 32'd0);
        chk("midrst_data", data_a, 32'd0);
        chk("midrst_drop", 32'(drop_a), 32'd0);
        snap_v_i = 1'b1; global_ctr_i = 32'd400; snap_tag_i = 32'h33;
        #1;
        chk("yumi_after_rst", 32'(yumi_a), 32'd1);
        tick();
        snap_v_i = 1'b0;
        expect_readout(0, 32'd400, 32'h33, 32'd0, 32'd0, 32'd0, 32'd0);

        // Clear-on-snap: counter 7 with an event in the accept cycle
        do_reset();
        event_i = 4'b0010;
        repeat (7) tick();
        snap_v_i = 1'b1; global_ctr_i = 32'd500; snap_tag_i = 32'h44;
        tick();
        snap_v_i = 1'b0; event_i = 4'b0000;
        expect_readout(1, 32'd500, 32'h44, 32'd0, 32'd7, 32'd0, 32'd0);
        snap_v_i = 1'b1; global_ctr_i = 32'd600; snap_tag_i = 32'h55;
        tick();
        snap_v_i = 1'b0;
        expect_readout(1, 32'd600, 32'h55, 32'd0, 32'd1, 32'd0, 32'd0);

        // 8-bit counters: 260 events wrap or saturate
        do_reset();
        event_i = 4'b0001;
        repeat (260) tick();
        event_i = 4'b0000;
        snap_v_i = 1'b1; global_ctr_i = 32'd700; snap_tag_i = 32'h66;
        tick();
        snap_v_i = 1'b0;
        expect_readout(2, 32'd700, 32'h66, WRAP_EXP, 32'd0, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
